// File: rtl/opr1_sequencer.sv
// opr1_sequencer: steps PDP-8 Group-1 operate microinstructions through the
// Link/AC/rotater datapath as an ordered series of strobed events.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for START; decodes IR and launches first event
// S_STRB | L_ck/AC_ck high for STROBE_W cycles, event controls valid
// S_GAP  | strobes low for GAP_W cycles, controls held for the Link
// S_FIN  | DONE (and possibly ERR) pulse; START ignored; back to IDLE
module opr1_sequencer #(
  parameter int STROBE_W = 1,
  parameter int GAP_W    = 1
) (
  input  logic        clk,
  input  logic        CLEAR_N,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic        AC_ONES,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        L_ck,
  output logic        L_clear,
  output logic        L_compl,
  output logic        L_force,
  output logic        AC_ck,
  output logic        AC_clear,
  output logic        AC_compl,
  output logic        AC_inc,
  output logic [1:0]  ROT_SEL
);

  typedef enum logic [1:0] {S_IDLE, S_STRB, S_GAP, S_FIN} state_t;
  typedef enum logic [2:0] {
    EV_NONE = 3'd0, EV_CLR = 3'd1, EV_CMP = 3'd2,
    EV_INC  = 3'd3, EV_ROT1 = 3'd4, EV_ROT2 = 3'd5
  } ev_t;

  typedef struct packed {
    logic       l_clear;
    logic       l_compl;
    logic       l_force;
    logic       ac_clear;
    logic       ac_compl;
    logic       ac_inc;
    logic [1:0] rot_sel;
  } ctl_t;

  localparam int MAXW = (STROBE_W > GAP_W) ? STROBE_W : GAP_W;
  localparam int CW   = (MAXW < 2) ? 1 : $clog2(MAXW + 1);
  localparam logic [CW-1:0] STRB_LD = CW'(STROBE_W - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_W - 1);

  // RAR and RAL together cancel; BSW alone still gives one byte-swap event.
  function automatic logic ev_active(input ev_t e, input logic [7:0] ir);
    case (e)
      EV_CLR:  return ir[7] | ir[6];
      EV_CMP:  return ir[5] | ir[4];
      EV_INC:  return ir[0];
      EV_ROT1: return (ir[3] ^ ir[2]) | (ir[1] & ~ir[3] & ~ir[2]);
      EV_ROT2: return ir[1] & (ir[3] ^ ir[2]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic ev_t next_ev(input ev_t cur, input logic [7:0] ir);
    if (cur < EV_CLR  && ev_active(EV_CLR,  ir)) return EV_CLR;
    if (cur < EV_CMP  && ev_active(EV_CMP,  ir)) return EV_CMP;
    if (cur < EV_INC  && ev_active(EV_INC,  ir)) return EV_INC;
    if (cur < EV_ROT1 && ev_active(EV_ROT1, ir)) return EV_ROT1;
    if (cur < EV_ROT2 && ev_active(EV_ROT2, ir)) return EV_ROT2;
    return EV_NONE;
  endfunction

  // Only the current event's controls are set so the rotater sees plain L.
  function automatic ctl_t ev_ctl(input ev_t e, input logic [7:0] ir, input logic ac_ones);
    ctl_t c;
    c = '0;
    case (e)
      EV_CLR: begin
        c.l_clear  = ir[6];
        c.ac_clear = ir[7];
      end
      EV_CMP: begin
        c.l_compl  = ir[4];
        c.ac_compl = ir[5];
      end
      EV_INC: begin
        c.ac_inc  = 1'b1;
        c.l_compl = ac_ones;
      end
      EV_ROT1, EV_ROT2: begin
        c.l_force = 1'b1;
        c.rot_sel = ir[3] ? 2'd1 : (ir[2] ? 2'd2 : 2'd3);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  ev_t           ev_q, ev_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ir_q, ir_d;
  ctl_t          ctl_q, ctl_d;
  logic          ck_q, ck_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          go;

  // Next-state and registered-output decode; defaults drop every output to 0.
  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    ctl_d   = '0;
    ck_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    nxt     = EV_NONE;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (IR[11:9] == 3'b111 && !IR[8]) begin
            ir_d = IR[7:0];
            nxt  = next_ev(EV_NONE, IR[7:0]);
            go   = 1'b1;
          end else begin
            state_d = S_FIN;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_STRB: begin
        busy_d = 1'b1;
        ctl_d  = ctl_q;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          ck_d  = 1'b1;
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          nxt = next_ev(ev_q, ir_q);
          go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          ctl_d = ctl_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ev_d    = EV_NONE;
      end
    endcase
    if (go) begin
      busy_d = 1'b1;
      if (nxt == EV_NONE) begin
        state_d = S_FIN;
        ev_d    = EV_NONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_STRB;
        ev_d    = nxt;
        cnt_d   = STRB_LD;
        ck_d    = 1'b1;
        ctl_d   = ev_ctl(nxt, ir_d, AC_ONES);
      end
    end
  end

  // State and output registers; CLEAR_N aborts any sequence immediately.
  always_ff @(posedge clk or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      state_q <= S_IDLE;
      ev_q    <= EV_NONE;
      cnt_q   <= '0;
      ir_q    <= '0;
      ctl_q   <= '0;
      ck_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
      ck_q    <= ck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign L_ck     = ck_q;
  assign AC_ck    = ck_q;
  assign L_clear  = ctl_q.l_clear;
  assign L_compl  = ctl_q.l_compl;
  assign L_force  = ctl_q.l_force;
  assign AC_clear = ctl_q.ac_clear;
  assign AC_compl = ctl_q.ac_compl;
  assign AC_inc   = ctl_q.ac_inc;
  assign ROT_SEL  = ctl_q.rot_sel;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Bench for opr1_sequencer with a small Link/AC/rotater model that
// edge-detects L_ck, so the effect of each sequence on L and AC is visible.
module tb_opr1_sequencer;

  logic        clk = 1'b0;
  logic        CLEAR_N, START, AC_ONES;
  logic [11:0] IR;
  logic        BUSY, DONE, ERR, L_ck, L_clear, L_compl, L_force;
  logic        AC_ck, AC_clear, AC_compl, AC_inc;
  logic [1:0]  ROT_SEL;

  int n_tests = 0;
  int n_fail  = 0;

  opr1_sequencer #(.STROBE_W(1), .GAP_W(1)) dut (
    .clk(clk), .CLEAR_N(CLEAR_N), .START(START), .IR(IR), .AC_ONES(AC_ONES),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .L_ck(L_ck), .L_clear(L_clear),
    .L_compl(L_compl), .L_force(L_force), .AC_ck(AC_ck), .AC_clear(AC_clear),
    .AC_compl(AC_compl), .AC_inc(AC_inc), .ROT_SEL(ROT_SEL)
  );

  always #5 clk = ~clk;

  // Link/AC datapath model
  logic        m_l, lck_prev, ld_en, ld_l, nl;
  logic [11:0] m_ac, ld_ac, na;

  assign AC_ONES = (m_ac == 12'o7777);

  always @(posedge clk) begin
    lck_prev <= L_ck;
    if (ld_en) begin
      m_l  <= ld_l;
      m_ac <= ld_ac;
    end else if (L_ck && !lck_prev) begin
      nl = m_l;
      na = m_ac;
      if (AC_clear) na = 12'o0000;
      if (L_clear)  nl = 1'b0;
      if (AC_compl) na = ~na;
      if (L_compl)  nl = ~nl;
      if (AC_inc)   na = na + 12'd1;
      if (L_force) begin
        case (ROT_SEL)
          2'd1: {nl, na} = {na[0], nl, na[11:1]};
          2'd2: {nl, na} = {na, nl};
          2'd3: na = {na[5:0], na[11:6]};
          default: ;
        endcase
      end
      m_l  <= nl;
      m_ac <= na;
    end
  end

  // per-cycle trace of outputs after a START
  logic       t_busy [0:15];
  logic       t_done [0:15];
  logic       t_err  [0:15];
  logic       t_lck  [0:15];
  logic       t_ack  [0:15];
  logic [7:0] t_ctl  [0:15];

  function automatic logic [12:0] obs(input int i);
    return {t_busy[i], t_done[i], t_err[i], t_lck[i], t_ack[i], t_ctl[i]};
  endfunction

  function automatic logic [12:0] ex(input logic b, input logic d, input logic e,
                                     input logic ck, input logic [7:0] c);
    return {b, d, e, ck, ck, c};
  endfunction

  task automatic sample(input int i);
    t_busy[i] = BUSY;
    t_done[i] = DONE;
    t_err[i]  = ERR;
    t_lck[i]  = L_ck;
    t_ack[i]  = AC_ck;
    t_ctl[i]  = {L_clear, L_compl, L_force, AC_clear, AC_compl, AC_inc, ROT_SEL};
  endtask

  task automatic preload(input logic l, input logic [11:0] ac);
    @(posedge clk); #1;
    ld_l = l; ld_ac = ac; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run(input logic [11:0] ir, input int n);
    @(posedge clk); #1;
    IR = ir; START = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      START = 1'b0;
      sample(i);
    end
  endtask

  task automatic test_reset();
    CLEAR_N = 1'b0; START = 1'b0; IR = 12'o0000; ld_en = 1'b0; ld_l = 1'b0; ld_ac = '0;
    #1;
    n_tests++;
    if ({BUSY, DONE, ERR, L_ck, AC_ck} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status got %b want 00000", {BUSY, DONE, ERR, L_ck, AC_ck});
    end
    n_tests++;
    if ({L_clear, L_compl, L_force, AC_clear, AC_compl, AC_inc, ROT_SEL} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 00000000",
               {L_clear, L_compl, L_force, AC_clear, AC_compl, AC_inc, ROT_SEL});
    end
    repeat (3) @(posedge clk);
    #1 CLEAR_N = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({BUSY, DONE, L_ck} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 000", {BUSY, DONE, L_ck});
    end
  endtask

  task automatic test_clear();
    logic [12:0] e;
    preload(1'b1, 12'o1234);
    run(12'o7300, 4);
    for (int i = 1; i <= 4; i++) begin
      e = ex(i <= 3, i == 3, 1'b0, i == 1, (i <= 2) ? 8'h90 : 8'h00);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL cla_cll cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    n_tests++;
    if ({m_l, m_ac} !== 13'b0) begin
      n_fail++;
      $display("FAIL cla_cll_data got L=%b AC=%o want L=0 AC=0000", m_l, m_ac);
    end
  endtask

  task automatic test_cml();
    logic [12:0] e;
    for (int k = 0; k < 2; k++) begin
      preload(k[0], 12'o0000);
      run(12'o7020, 4);
      for (int i = 1; i <= 4; i++) begin
        e = ex(i <= 3, i == 3, 1'b0, i == 1, (i <= 2) ? 8'h40 : 8'h00);
        n_tests++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL cml%0d cyc%0d got %b want %b", k, i, obs(i), e);
        end
      end
      n_tests++;
      if ({m_l, m_ac} !== {~k[0], 12'o0000}) begin
        n_fail++;
        $display("FAIL cml%0d_data got L=%b AC=%o want L=%b AC=0000", k, m_l, m_ac, ~k[0]);
      end
    end
  endtask

  task automatic test_iac();
    logic [12:0] e;
    preload(1'b0, 12'o7777);
    run(12'o7001, 4);
    for (int i = 1; i <= 4; i++) begin
      e = ex(i <= 3, i == 3, 1'b0, i == 1, (i <= 2) ? 8'h44 : 8'h00);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL iac_carry cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    n_tests++;
    if ({m_l, m_ac} !== {1'b1, 12'o0000}) begin
      n_fail++;
      $display("FAIL iac_carry_data got L=%b AC=%o want L=1 AC=0000", m_l, m_ac);
    end
    preload(1'b0, 12'o0001);
    run(12'o7001, 2);
    e = ex(1'b1, 1'b0, 1'b0, 1'b1, 8'h04);
    n_tests++;
    if (obs(1) !== e) begin
      n_fail++;
      $display("FAIL iac_nocarry got %b want %b", obs(1), e);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({m_l, m_ac} !== {1'b0, 12'o0002}) begin
      n_fail++;
      $display("FAIL iac_nocarry_data got L=%b AC=%o want L=0 AC=0002", m_l, m_ac);
    end
  endtask

  task automatic test_rotate();
    logic [12:0] e;
    preload(1'b1, 12'o0001);
    run(12'o7012, 6);
    for (int i = 1; i <= 6; i++) begin
      e = ex(i <= 5, i == 5, 1'b0, i == 1 || i == 3, (i <= 4) ? 8'h21 : 8'h00);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL rtr cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    n_tests++;
    if ({m_l, m_ac} !== {1'b0, 12'o6000}) begin
      n_fail++;
      $display("FAIL rtr_data got L=%b AC=%o want L=0 AC=6000", m_l, m_ac);
    end
    run(12'o7014, 3);
    for (int i = 1; i <= 3; i++) begin
      e = ex(i == 1, i == 1, 1'b0, 1'b0, 8'h00);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL rar_ral cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    preload(1'b1, 12'o0077);
    run(12'o7002, 4);
    for (int i = 1; i <= 4; i++) begin
      e = ex(i <= 3, i == 3, 1'b0, i == 1, (i <= 2) ? 8'h23 : 8'h00);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL bsw cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    n_tests++;
    if ({m_l, m_ac} !== {1'b1, 12'o7700}) begin
      n_fail++;
      $display("FAIL bsw_data got L=%b AC=%o want L=1 AC=7700", m_l, m_ac);
    end
  endtask

  task automatic test_nop_err();
    logic [12:0] e;
    logic [11:0] irs [0:2];
    irs[0] = 12'o7000; irs[1] = 12'o5000; irs[2] = 12'o7400;
    for (int k = 0; k < 3; k++) begin
      run(irs[k], 3);
      for (int i = 1; i <= 3; i++) begin
        e = ex(i == 1, i == 1, (i == 1) && (k != 0), 1'b0, 8'h00);
        n_tests++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL nop_err ir=%o cyc%0d got %b want %b", irs[k], i, obs(i), e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic [7:0]  c;
    @(posedge clk); #1;
    IR = 12'o7300; START = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      sample(i);
      if (i <= 4) begin
        IR = 12'o7020; START = 1'b1;
      end else begin
        START = 1'b0;
      end
    end
    for (int i = 1; i <= 8; i++) begin
      c = (i <= 2) ? 8'h90 : ((i == 5 || i == 6) ? 8'h40 : 8'h00);
      e = ex(i != 4 && i != 8, i == 3 || i == 7, 1'b0, i == 1 || i == 5, c);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d got %b want %b", i, obs(i), e);
      end
    end
  endtask

  task automatic test_abort();
    logic [12:0] e;
    int          strobes;
    preload(1'b0, 12'o0000);
    run(12'o7361, 4);
    for (int i = 1; i <= 4; i++) begin
      e = ex(1'b1, 1'b0, 1'b0, i == 1 || i == 3, (i <= 2) ? 8'h90 : 8'h48);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL abort_pre cyc%0d got %b want %b", i, obs(i), e);
      end
    end
    CLEAR_N = 1'b0;
    #1;
    sample(0);
    n_tests++;
    if (obs(0) !== 13'b0) begin
      n_fail++;
      $display("FAIL abort_async got %b want %b", obs(0), 13'b0);
    end
    repeat (2) @(posedge clk);
    #1 CLEAR_N = 1'b1;
    strobes = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (L_ck || BUSY || DONE || L_compl || AC_inc) strobes++;
    end
    n_tests++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL abort_after got %0d active cycles want 0", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_cml();
    test_iac();
    test_rotate();
    test_nop_err();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
